uart_rx_ctrl: RTL and testbench

Receive-side control and datapath for the board's UART link. Synchronizes the serial line, detects the start bit, times mid-bit samples with an internal baud timer, counts data bits and shifts them into a parallel word, checks the stop bit and delivers the word to the consumer through a valid/ack handshake. It sits between the `rx_in` pad and the downstream byte consumer.

---
 rtl/uart_rx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive control and datapath.
// Syncs rx_in, times mid-bit samples, shifts in the word, checks stop.
// Ports: clk, rst (sync, active high), rx_in (serial, idle high),
//   rx_data/rx_valid/rx_ack (word handshake), frame_err, overrun,
//   parity_err (one-cycle pulses).
// Option: define UART_RX_PARITY_EN for an even-parity bit after data.
module uart_rx_ctrl #(
  parameter int BAUD_DIV  = 5208,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] T_MID = TW'(BAUD_DIV/2 - 1);
  localparam logic [TW-1:0] T_END = TW'(BAUD_DIV - 1);
  localparam logic [3:0]    NBITS = 4'(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 deliver;
  logic                 sin;

`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  assign sin = sync_q[1];

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == T_END) ? '0 : tmr_q + 1'b1;
    cnt_d   = cnt_q;
    shr_d   = shr_q;
    data_d  = data_q;
    // A pending word is consumed by ack; a new delivery below wins.
    valid_d = valid_q & ~rx_ack;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (!sin) state_d = S_START;
      end
      S_START: begin
        if (tmr_q == T_MID) begin
          state_d = sin ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tmr_q == T_END) begin
          shr_d = {sin, shr_q[DATA_BITS-1:1]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == NBITS) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tmr_q == T_END) begin
          // Even parity: data XOR parity bit must be zero.
          pbad_d  = (^shr_q) ^ sin;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tmr_q == T_END) begin
          state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
          perr_d = pbad_q;
          if (!sin) ferr_d = 1'b1;
          else if (!pbad_q) deliver = 1'b1;
`else
          if (!sin) ferr_d = 1'b1;
          else deliver = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      data_d  = shr_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rx_ack;
    end

    if (state_d != state_q) tmr_d = '0;
    if (state_d == S_DATA && state_q != S_DATA) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      tmr_q   <= '0;
      cnt_q   <= '0;
      shr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_in};
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      shr_q   <= shr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pbad_q <= pbad_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl.
// BAUD_DIV=16, DATA_BITS=8; parity steps only with UART_RX_PARITY_EN.
module tb_uart_rx_ctrl;

  localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  int ferr_n = 0;
  int ovr_n  = 0;
  int perr_n = 0;
  logic vprev = 1'b0;

  uart_rx_ctrl #(
    .BAUD_DIV (BD),
    .DATA_BITS(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err)  ferr_n++;
    if (overrun)    ovr_n++;
    if (parity_err) perr_n++;
    if (rx_valid && !vprev) rise_cyc = cyc;
    vprev = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    ferr_n = 0;
    ovr_n  = 0;
    perr_n = 0;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that
  // ends the stop bit, with the line left at the stop-bit value.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic bad_par);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (P == 1) drive_bit((^d) ^ bad_par);
    drive_bit(stop_b);
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_ovr",   32'(overrun), 32'h0);
    check("rst_perr",  32'(parity_err), 32'h0);
    rst = 1'b0;
    idle(5);

    // Good frame 0xA5; sin goes low 2 cycles after rx_in, and
    // rx_valid follows 153 (+16 with parity) cycles after that.
    clr_counts();
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_data",  32'(rx_data), 32'hA5);
    check("a5_valid", 32'(rx_valid), 32'h1);
    check("a5_lat",   32'(rise_cyc - start_cyc), 32'(155 + 16 * P));
    check("a5_errs",  32'(ferr_n + ovr_n + perr_n), 32'h0);
    ack_once();
    check("a5_ack_clr", 32'(rx_valid), 32'h0);

    // Short low glitch: false start.
    clr_counts();
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    check("gl_valid", 32'(rx_valid), 32'h0);
    check("gl_errs",  32'(ferr_n + ovr_n + perr_n), 32'h0);
    check("gl_idle",  32'(dut.state_q), 32'h0);

    // Bad stop bit.
    clr_counts();
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    check("fe_pulse", 32'(ferr_n), 32'h1);
    check("fe_valid", 32'(rx_valid), 32'h0);
    check("fe_data",  32'(rx_data), 32'hA5);
    check("fe_ovr",   32'(ovr_n), 32'h0);

    // Back-to-back, no ack: overrun.
    clr_counts();
    send_frame(8'h11, 1'b1, 1'b0);
    check("b1_data", 32'(rx_data), 32'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ov_pulse", 32'(ovr_n), 32'h1);
    check("ov_data",  32'(rx_data), 32'h22);
    check("ov_valid", 32'(rx_valid), 32'h1);

    // Back-to-back with ack in the completion cycle: no overrun.
    ack_once();
    clr_counts();
    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        repeat (154 + 16 * P) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
      end
    join
    check("ak_ovr",   32'(ovr_n), 32'h0);
    check("ak_data",  32'(rx_data), 32'h22);
    check("ak_valid", 32'(rx_valid), 32'h1);

    // Reset during data bit 4 of a frame, then a clean frame.
    clr_counts();
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        repeat (88) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mr_data",  32'(rx_data), 32'h0);
        check("mr_valid", 32'(rx_valid), 32'h0);
        check("mr_pulse",
              32'({frame_err, overrun, parity_err}), 32'h0);
        rst = 1'b0;
      end
    join
    idle(5);
    check("mr_quiet", 32'(rx_valid), 32'h0);
    clr_counts();
    send_frame(8'h5A, 1'b1, 1'b0);
    check("5a_data",  32'(rx_data), 32'h5A);
    check("5a_valid", 32'(rx_valid), 32'h1);
    check("5a_errs",  32'(ferr_n + ovr_n + perr_n), 32'h0);
    ack_once();

`ifdef UART_RX_PARITY_EN
    clr_counts();
    send_frame(8'h07, 1'b1, 1'b0);
    check("pg_data",  32'(rx_data), 32'h07);
    check("pg_valid", 32'(rx_valid), 32'h1);
    check("pg_perr",  32'(perr_n), 32'h0);
    ack_once();
    clr_counts();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(5);
    check("pb_perr",  32'(perr_n), 32'h1);
    check("pb_valid", 32'(rx_valid), 32'h0);
    check("pb_ferr",  32'(ferr_n), 32'h0);
`else
    check("np_perr", 32'(parity_err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
